run_ctrl: RTL
=============

Name: run_ctrl

Overview:
- Run sequencer and data-memory port arbiter for the EnDMe processor.
- Lets a host preload and read back data_mem while the core is idle.
- On start, holds the core in reset, then releases it and counts cycles.
- Detects the halt instruction or a cycle timeout and reports done; sits between the host/testbench, top_level's RESET input and the data_mem port.

Parameters:
- ADDR_W, 8, data_mem address width
- DATA_W, 8, data_mem data width
- CNT_W, 16, cycle counter width
- HALT_OP, 9'h1FF, instruction encoding that ends a run
- MAX_CYCLES, 16'hFFFF, run cycle limit before forced stop (must be >= 1)
- RST_CYCLES, 2, cycles core_reset is held after start (must be >= 1)

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- start  in  1  begin a run (sampled in IDLE/DONE)
- host_req  in  1  host requests data_mem port
- host_we  in  1  host write enable
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host owns port this cycle
- host_rdata  out  DATA_W  read data to host (0 when not granted)
- core_instr  in  9  instruction currently fetched by core
- core_mem_addr  in  ADDR_W  core data address
- core_mem_wdata  in  DATA_W  core write data
- core_mem_we  in  1  core write enable
- mem_addr  out  ADDR_W  to data_mem addr_in
- mem_wdata  out  DATA_W  to data_mem data_in
- mem_we  out  1  to data_mem writemem_ctrl
- mem_rdata  in  DATA_W  from data_mem data_out (combinational read)
- core_reset  out  1  active-high reset to processor
- busy  out  1  RST or RUN state
- done  out  1  run finished (sticky)
- timeout  out  1  run ended by MAX_CYCLES (sticky)
- cycle_count  out  CNT_W  core cycles executed in last/current run

Behaviour:
- States: IDLE, RST, RUN, DONE. Registered state, registered counters.
- Reset (RESET_N low, any time, including mid-run):
  - State goes to IDLE immediately.
  - core_reset=1; busy=done=timeout=0; cycle_count=0; mem_we=0; host_gnt=0.
- IDLE:
  - start=1 -> RST; clears cycle_count, done, timeout; loads reset counter with RST_CYCLES-1.
- RST:
  - core_reset=1 for exactly RST_CYCLES cycles, then -> RUN.
- RUN:
  - core_reset=0; core owns the memory port; cycle_count increments every cycle.
  - core_instr==HALT_OP -> DONE, done=1 next edge; the halt cycle is counted.
  - Otherwise, if cycle_count==MAX_CYCLES-1 -> DONE with done=1, timeout=1.
  - Halt wins if both conditions occur in the same cycle (timeout stays 0).
  - start is ignored.
- DONE:
  - core_reset=1; done, timeout and cycle_count hold.
  - start=1 -> RST with the same clears as from IDLE.
- Arbitration:
  - Combinational mux on state: host_gnt = host_req & (IDLE|DONE) & ~start.
  - Simultaneous start and host_req: start wins, host_gnt=0, host write dropped.
  - Granted host: mem_addr=host_addr, mem_wdata=host_wdata, mem_we=host_we, host_rdata=mem_rdata (0-latency read).
  - RUN: mem_* driven from core_mem_*; mem_we=core_mem_we.
  - All other cases: mem_we=0, mem_addr/mem_wdata=0.
  - Core writes outside RUN never reach memory.
- busy=1 exactly in RST and RUN.
- cycle_count saturates only via the timeout; no wrap within a run.

Optional Feature:
- Macro: RUN_CTRL_WRCOUNT_EN.
- Defined:
  - Adds output core_wr_count out CNT_W.
  - Counts RUN cycles with core_mem_we=1.
  - Cleared by reset and on the start transition; held in DONE.
- Undefined:
  - Port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-run: assert RESET_N low during RUN at cycle 5 -> same-cycle IDLE, core_reset=1, cycle_count=0, done=0.
- Host preload: in IDLE, host writes 8'hA5 to addr 8'h10, then reads addr 8'h10 -> host_gnt=1 both cycles, mem_we=1 on write only, host_rdata=8'hA5.
- Normal run: start pulse, core_instr=HALT_OP on 4th RUN cycle:
  - core_reset=1 for 2 cycles, then 0.
  - done=1 and cycle_count=4; timeout=0; busy falls with done.
- Timeout: MAX_CYCLES=10, halt never fetched -> DONE after 10 RUN cycles, cycle_count=10, done=1, timeout=1.
- Contention:
  - host_req=1 with start=1 in IDLE -> host_gnt=0, mem_we=0, enters RST.
  - host_req during RUN -> host_gnt=0; core write addr 8'h20 data 8'h3C reaches mem_* unchanged.
- Restart from DONE: start -> done/timeout/cycle_count clear on entering RST; with RUN_CTRL_WRCOUNT_EN, core_wr_count clears, then equals the number of core_mem_we cycles in the new run (e.g. 3).

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl -- run sequencer and data_mem port arbiter for the EnDMe processor.
//
// Lets a host preload and read back data_mem while the core is idle. On
// start, holds the core in reset for RST_CYCLES cycles, then releases it and
// counts cycles until the halt instruction is fetched or MAX_CYCLES expires.
//
// Ports:
//   CLK, RESET_N                  clock (rising edge), async active-low reset
//   start                         begin a run (sampled in IDLE/DONE)
//   host_req/we/addr/wdata        host access request to data_mem
//   host_gnt, host_rdata          host grant and 0-latency read data
//   core_instr                    instruction fetched by the core (halt detect)
//   core_mem_addr/wdata/we        core data_mem access
//   mem_addr/wdata/we, mem_rdata  data_mem port
//   core_reset                    active-high reset to the processor
//   busy, done, timeout           run status (done/timeout sticky)
//   cycle_count                   core cycles executed in last/current run
//
// Build option:
//   RUN_CTRL_WRCOUNT_EN  adds output core_wr_count, the number of RUN cycles
//                        with core_mem_we=1 in the last/current run.
//
// state | meaning
// IDLE  | after reset; host may own the memory port
// RST   | core held in reset for RST_CYCLES cycles
// RUN   | core running and owns the memory port; cycles counted
// DONE  | run ended (halt or timeout); host may own the memory port

module run_ctrl #(
  parameter int         ADDR_W     = 8,
  parameter int         DATA_W     = 8,
  parameter int         CNT_W      = 16,
  parameter logic [8:0] HALT_OP    = 9'h1FF,
  parameter int         MAX_CYCLES = 16'hFFFF,
  parameter int         RST_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  input  logic [8:0]        core_instr,
  input  logic [ADDR_W-1:0] core_mem_addr,
  input  logic [DATA_W-1:0] core_mem_wdata,
  input  logic              core_mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
`ifdef RUN_CTRL_WRCOUNT_EN
  ,
  output logic [CNT_W-1:0]  core_wr_count
`endif
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [RW-1:0] rst_cnt;
  logic          host_side;
  logic          launch;

  assign host_side = (state == S_IDLE) || (state == S_DONE);
  assign launch    = host_side && start;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      core_reset  <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RST;
            rst_cnt     <= RW'(RST_CYCLES - 1);
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b1;
            core_reset  <= 1'b1;
          end
        end
        S_RST: begin
          if (rst_cnt == '0) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - RW'(1);
          end
        end
        S_RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          // halt takes priority over a coincident timeout
          if (core_instr == HALT_OP) begin
            state      <= S_DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            core_reset <= 1'b1;
          end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
            state      <= S_DONE;
            done       <= 1'b1;
            timeout    <= 1'b1;
            busy       <= 1'b0;
            core_reset <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

  // start beats a same-cycle host request; grant is forced low during reset
  assign host_gnt   = RESET_N && host_req && !start && host_side;
  assign host_rdata = host_gnt ? mem_rdata : '0;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end else if (state == S_RUN) begin
      mem_addr  = core_mem_addr;
      mem_wdata = core_mem_wdata;
      mem_we    = core_mem_we;
    end
  end

`ifdef RUN_CTRL_WRCOUNT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      core_wr_count <= '0;
    end else if (launch) begin
      core_wr_count <= '0;
    end else if (state == S_RUN && core_mem_we) begin
      core_wr_count <= core_wr_count + CNT_W'(1);
    end
  end
`else
  // no core write counter in this build; launch only feeds that counter
  logic unused_launch;
  assign unused_launch = launch;
`endif

endmodule
